// File: rtl/core_pkg.sv
// Shared core encodings: scheduler phases, per-thread LSU states and LSU issuer states.
package core_pkg;

  localparam logic [2:0] CORE_IDLE    = 3'b000;
  localparam logic [2:0] CORE_FETCH   = 3'b001;
  localparam logic [2:0] CORE_DECODE  = 3'b010;
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_WAIT    = 3'b100;
  localparam logic [2:0] CORE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam logic [2:0] CORE_DONE    = 3'b111;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_t;

  typedef enum logic {
    ISSUE_IDLE = 1'b0,
    ISSUE_BUSY = 1'b1
  } issue_state_t;

endpackage

// File: rtl/lsu_thread_select.sv
// Lowest-index priority encoder over the mask of threads waiting to be issued.
module lsu_thread_select #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  requesting,
  output logic          any,
  output logic [IW-1:0] index
);

  always_comb begin
    any   = 1'b0;
    index = '0;
    // Descending scan so the lowest set bit is the one left standing.
    for (int i = N - 1; i >= 0; i--) begin
      if (requesting[i]) begin
        any   = 1'b1;
        index = IW'(i);
      end
    end
  end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit: captures per-thread requests on REQUEST and serialises them onto a
// single valid/ready data-memory port, lowest thread first.
module core_lsu
  import core_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int ADDR_BITS         = 8,
  parameter int DATA_BITS         = 8
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [THREADS_PER_BLOCK-1:0]                 thread_enable,
  input  logic [2:0]                                   core_state,
  input  logic                                         decoded_mem_read_enable,
  input  logic                                         decoded_mem_write_enable,
  input  logic [THREADS_PER_BLOCK-1:0][DATA_BITS-1:0]  rs,
  input  logic [THREADS_PER_BLOCK-1:0][DATA_BITS-1:0]  rt,
  output logic                                         mem_valid,
  output logic                                         mem_write,
  output logic [ADDR_BITS-1:0]                         mem_addr,
  output logic [DATA_BITS-1:0]                         mem_wdata,
  input  logic                                         mem_ready,
  input  logic [DATA_BITS-1:0]                         mem_rdata,
  output logic [THREADS_PER_BLOCK-1:0][1:0]            lsu_state,
  output logic [THREADS_PER_BLOCK-1:0][DATA_BITS-1:0]  lsu_out
);

  localparam int T  = THREADS_PER_BLOCK;
  localparam int IW = (T > 1) ? $clog2(T) : 1;

  logic [T-1:0][1:0]           st_q, st_d;
  logic [T-1:0]                wr_q, wr_d;
  logic [T-1:0][ADDR_BITS-1:0] addr_q, addr_d;
  logic [T-1:0][DATA_BITS-1:0] data_q, data_d;
  logic [T-1:0][DATA_BITS-1:0] out_q, out_d;
  issue_state_t                iss_q, iss_d;
  logic [IW-1:0]               cur_q, cur_d;
  logic                        mwr_q, mwr_d;
  logic [ADDR_BITS-1:0]        maddr_q, maddr_d;
  logic [DATA_BITS-1:0]        mdata_q, mdata_d;

  logic [T-1:0]  req_mask;
  logic          sel_any;
  logic [IW-1:0] sel_idx;
  logic          capture, select, hs;
  logic          unused_rs;

  assign unused_rs = ^rs;

  always_comb begin
    for (int i = 0; i < T; i++) req_mask[i] = (st_q[i] == LSU_REQUESTING);
  end

  lsu_thread_select #(.N(T), .IW(IW)) u_sel (
    .requesting (req_mask),
    .any        (sel_any),
    .index      (sel_idx)
  );

  assign capture = (core_state == CORE_REQUEST) &&
                   (decoded_mem_read_enable || decoded_mem_write_enable);
  assign select  = (iss_q == ISSUE_IDLE) && sel_any;
  assign hs      = (iss_q == ISSUE_BUSY) && mem_ready;

  always_comb begin
    iss_d   = iss_q;
    cur_d   = cur_q;
    mwr_d   = mwr_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    st_d    = st_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    out_d   = out_q;

    case (iss_q)
      ISSUE_IDLE: if (select) begin
        iss_d   = ISSUE_BUSY;
        cur_d   = sel_idx;
        mwr_d   = wr_q[sel_idx];
        maddr_d = addr_q[sel_idx];
        mdata_d = data_q[sel_idx];
      end
      ISSUE_BUSY: if (mem_ready) iss_d = ISSUE_IDLE;
      default:    iss_d = ISSUE_IDLE;
    endcase

    for (int i = 0; i < T; i++) begin
      case (st_q[i])
        LSU_IDLE: if (capture && thread_enable[i]) begin
          st_d[i]   = LSU_REQUESTING;
          addr_d[i] = rs[i][ADDR_BITS-1:0];
          data_d[i] = rt[i];
          // A simultaneous read+write decodes as a load.
          wr_d[i]   = decoded_mem_write_enable && !decoded_mem_read_enable;
        end
        LSU_REQUESTING: if (select && sel_idx == IW'(i)) st_d[i] = LSU_WAITING;
        LSU_WAITING: if (hs && cur_q == IW'(i)) begin
          st_d[i] = LSU_DONE;
          if (!mwr_q) out_d[i] = mem_rdata;
        end
        default: if (core_state == CORE_UPDATE) st_d[i] = LSU_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iss_q   <= ISSUE_IDLE;
      cur_q   <= '0;
      mwr_q   <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
      st_q    <= '0;
      wr_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      out_q   <= '0;
    end else begin
      iss_q   <= iss_d;
      cur_q   <= cur_d;
      mwr_q   <= mwr_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      st_q    <= st_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      out_q   <= out_d;
    end
  end

  assign mem_valid = (iss_q == ISSUE_BUSY);
  assign mem_write = mwr_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mdata_q;
  assign lsu_state = st_q;
  assign lsu_out   = out_q;

endmodule

// File: tb/tb_core_lsu.sv
// Randomised bench for core_lsu against a transaction-level queue model of the LSU.
module tb_core_lsu;
  import core_pkg::*;

  localparam int T = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [T-1:0]        thread_enable;
  logic [2:0]          core_state;
  logic                rd, wr;
  logic [T-1:0][7:0]   rs, rt;
  logic                mem_valid, mem_write;
  logic [7:0]          mem_addr, mem_wdata;
  logic                mem_ready;
  logic [7:0]          mem_rdata;
  logic [T-1:0][1:0]   lsu_state;
  logic [T-1:0][7:0]   lsu_out;

  core_lsu #(.THREADS_PER_BLOCK(T), .ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .thread_enable            (thread_enable),
    .core_state               (core_state),
    .decoded_mem_read_enable  (rd),
    .decoded_mem_write_enable (wr),
    .rs                       (rs),
    .rt                       (rt),
    .mem_valid                (mem_valid),
    .mem_write                (mem_write),
    .mem_addr                 (mem_addr),
    .mem_wdata                (mem_wdata),
    .mem_ready                (mem_ready),
    .mem_rdata                (mem_rdata),
    .lsu_state                (lsu_state),
    .lsu_out                  (lsu_out)
  );

  always #5 clk = ~clk;

  // Reference model: per-thread state, pending-request queue, thread in service.
  int        exp_st[T];
  logic [7:0] exp_out[T], e_addr[T], e_dat[T];
  bit        e_wr[T];
  int        pq[$];
  int        cur;
  int        edge_cnt, issue_edge[T], done_edge[T];
  int        dut_writes;
  logic [7:0] key;
  int        n_cmp, n_bad;

  function automatic logic [7:0] fmem(input logic [7:0] a);
    return (a + 8'h10) ^ key;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < T; i++) begin
      exp_st[i] = 0; exp_out[i] = '0; e_addr[i] = '0; e_dat[i] = '0; e_wr[i] = 0;
    end
    pq.delete();
    cur = -1;
  endtask

  task automatic model_edge(input logic [2:0] cs, input logic rdy);
    int nst[T];
    edge_cnt++;
    for (int i = 0; i < T; i++) nst[i] = exp_st[i];
    if (cs == CORE_UPDATE)
      for (int i = 0; i < T; i++) if (exp_st[i] == 3) nst[i] = 0;
    if (cur >= 0) begin
      if (rdy) begin
        nst[cur] = 3;
        if (!e_wr[cur]) exp_out[cur] = fmem(e_addr[cur]);
        done_edge[cur] = edge_cnt;
        cur = -1;
      end
    end else if (pq.size() > 0) begin
      cur = pq.pop_front();
      nst[cur] = 2;
      issue_edge[cur] = edge_cnt;
    end
    if (cs == CORE_REQUEST && (rd || wr))
      for (int i = 0; i < T; i++)
        if (exp_st[i] == 0 && thread_enable[i]) begin
          nst[i] = 1; e_addr[i] = rs[i]; e_dat[i] = rt[i]; e_wr[i] = wr && !rd;
          pq.push_back(i);
        end
    for (int i = 0; i < T; i++) exp_st[i] = nst[i];
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < T; i++) begin
      chk($sformatf("%s.st%0d", tag, i), 32'(lsu_state[i]), 32'(exp_st[i]));
      chk($sformatf("%s.out%0d", tag, i), 32'(lsu_out[i]), 32'(exp_out[i]));
    end
    chk({tag, ".vld"}, 32'(mem_valid), 32'(cur >= 0));
    if (cur >= 0) begin
      chk({tag, ".wr"}, 32'(mem_write), 32'(e_wr[cur]));
      chk({tag, ".addr"}, 32'(mem_addr), 32'(e_addr[cur]));
      if (e_wr[cur]) chk({tag, ".wdata"}, 32'(mem_wdata), 32'(e_dat[cur]));
    end
  endtask

  task automatic cycle(input logic [2:0] cs, input logic rdy, input string tag);
    @(negedge clk);
    check_all(tag);
    core_state = cs;
    mem_ready  = rdy;
    mem_rdata  = fmem(mem_addr);
    if (mem_valid && rdy && mem_write) dut_writes++;
    if (cs != CORE_REQUEST) begin
      rs = 32'($urandom());
      rt = 32'($urandom());
    end
    @(posedge clk);
    model_edge(cs, rdy);
  endtask

  task automatic request(input logic [T-1:0] en, input logic r, input logic w,
                         input logic [31:0] rsv, input logic [31:0] rtv, input string tag);
    thread_enable = en; rd = r; wr = w;
    @(negedge clk);
    rs = rsv; rt = rtv;
    cycle(CORE_REQUEST, 1'($urandom_range(1)), tag);
  endtask

  // mode 0: ready high, 1: random ready/UPDATE, 2: hold ready low for 'hold' busy cycles
  task automatic drain(input int mode, input int hold, input int stop_thr, input string tag);
    int n = 0;
    int h = hold;
    logic r;
    logic [2:0] cs;
    while ((pq.size() > 0 || cur >= 0) && n < 200) begin
      cs = CORE_WAIT; r = 1'b1;
      if (mode == 1) begin
        r = ($urandom_range(2) != 0);
        if ($urandom_range(3) == 0) cs = CORE_UPDATE;
      end
      if (mode == 2 && cur >= 0 && h > 0) begin r = 1'b0; h--; end
      cycle(cs, r, tag);
      n++;
      if (stop_thr >= 0 && cur == stop_thr) return;
    end
    chk({tag, ".timeout"}, 32'(n >= 200), 32'(0));
  endtask

  int req_edge;

  initial begin
    n_cmp = 0; n_bad = 0; edge_cnt = 0; dut_writes = 0; key = '0;
    reset = 1'b1; thread_enable = '0; core_state = CORE_IDLE; rd = 0; wr = 0;
    rs = '0; rt = '0; mem_ready = 0; mem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    chk("rst.wr", 32'(mem_write), 0);
    chk("rst.addr", 32'(mem_addr), 0);
    chk("rst.wdata", 32'(mem_wdata), 0);
    cycle(CORE_IDLE, 1'b1, "rst");

    // Ordered loads, ready tied high
    request(4'hF, 1, 0, 32'h03020100, 32'h0, "ld");
    req_edge = edge_cnt;
    drain(0, 0, -1, "ld");
    #1;
    chk("ld.lat", (lsu_state == 8'hFF) ? 32'(edge_cnt - req_edge) : 32'hFFFF, 8);
    chk("ld.out", 32'(lsu_out), 32'h13121110);
    cycle(CORE_UPDATE, 1'b0, "upd");
    cycle(CORE_WAIT, 1'b0, "upd2");
    chk("upd.idle", 32'(lsu_state), 0);

    // Stores on threads 0 and 2 only
    dut_writes = 0;
    request(4'b0101, 0, 1, 32'h33221100, 32'h11AA2255, "st");
    drain(0, 0, -1, "st");
    cycle(CORE_WAIT, 1'b1, "st2");
    chk("st.nwr", 32'(dut_writes), 2);
    chk("st.out", 32'(lsu_out), 32'h13121110);
    cycle(CORE_UPDATE, 1'b0, "st3");

    // Backpressure on thread 0
    key = 8'h5C;
    request(4'b0011, 1, 0, 32'h00008070, 32'h0, "bp");
    drain(2, 3, -1, "bp");
    chk("bp.lat", 32'(done_edge[0] - issue_edge[0]), 4);

    // REQUEST while DONE is ignored; idle-but-disabled threads stay idle
    request(4'b0011, 1, 1, 32'h01020304, 32'h0, "rq2");
    cycle(CORE_WAIT, 1'b0, "rq2b");
    cycle(CORE_UPDATE, 1'b0, "rq2c");

    // Read and write both set decodes as load
    request(4'b0001, 1, 1, 32'h00000040, 32'h000000EE, "rw");
    drain(0, 0, -1, "rw");
    cycle(CORE_UPDATE, 1'b0, "rw2");

    // Asynchronous reset mid-transaction
    key = 8'h00;
    request(4'hF, 1, 0, 32'h23222120, 32'h0, "rs");
    drain(0, 0, 1, "rs");
    #2 reset = 1'b1;
    #1;
    chk("ar.vld", 32'(mem_valid), 0);
    chk("ar.st", 32'(lsu_state), 0);
    chk("ar.out", 32'(lsu_out), 0);
    model_reset();
    @(negedge clk); reset = 1'b0;
    cycle(CORE_WAIT, 1'b0, "ar2");

    // Random rounds
    for (int r = 0; r < 25; r++) begin
      key = 8'($urandom());
      if ($urandom_range(1) == 0) cycle(CORE_UPDATE, 1'($urandom_range(1)), "rnu");
      request(4'($urandom()), 1'($urandom_range(1)), 1'($urandom_range(1)),
              32'($urandom()), 32'($urandom()), "rnq");
      drain(1, 0, -1, "rnd");
      cycle(CORE_WAIT, 1'($urandom_range(1)), "rne");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_lsu.md
# core_lsu

Load/store unit for one compute core. It serves every thread of the active block and is the producer of the per-thread `lsu_state` vector that the core's scheduler polls during its WAIT phase. It captures per-thread memory requests when the scheduler enters REQUEST, then serialises them onto a single valid/ready data-memory port. It returns load data per thread and releases all threads back to IDLE when the scheduler enters UPDATE.

## Interface
Parameters:
- `THREADS_PER_BLOCK`, 4, number of thread lanes served.
- `ADDR_BITS`, 8, data-memory address width.
- `DATA_BITS`, 8, data word width.

Ports:
- `clk` in 1: single clock; all state is updated on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `thread_enable` in T: per-thread active mask for the current block.
- `core_state` in 3: scheduler state (REQUEST=3'b011, WAIT=3'b100, UPDATE=3'b110).
- `decoded_mem_read_enable` in 1: current instruction is a load.
- `decoded_mem_write_enable` in 1: current instruction is a store.
- `rs` in T×DATA_BITS: per-thread address operand; the low ADDR_BITS are used.
- `rt` in T×DATA_BITS: per-thread store data.
- `mem_valid` out 1: memory request valid.
- `mem_write` out 1: 1 = store, 0 = load; valid only while `mem_valid` is high.
- `mem_addr` out ADDR_BITS: request address.
- `mem_wdata` out DATA_BITS: store data.
- `mem_ready` in 1: memory accepts or completes the request this cycle; load data is valid on `mem_rdata`.
- `mem_rdata` in DATA_BITS: load data.
- `lsu_state` out T×2: per-thread state (IDLE 00, REQUESTING 01, WAITING 10, DONE 11).
- `lsu_out` out T×DATA_BITS: last load result per thread.

## Operation
- Each thread runs its own 2-bit FSM.
  - IDLE→REQUESTING at a rising edge where `core_state`==REQUEST, `thread_enable[i]`=1, and read or write enable is set. The edge also latches the address, the store data and the op for that thread.
  - REQUESTING→WAITING when the issuer selects the thread.
  - WAITING→DONE on the handshake edge (`mem_valid`&&`mem_ready`).
  - DONE→IDLE at an edge where `core_state`==UPDATE.
- If read and write enable are both set, the request is a load.
- Issuer FSM, two states:
  - ISSUE_IDLE: if any thread is REQUESTING, the issuer latches the lowest-index one, moves that thread to WAITING, and goes to ISSUE_BUSY.
  - ISSUE_BUSY: `mem_valid`=1 with that thread's op, address and data. On the handshake edge it writes `mem_rdata` into `lsu_out[i]` (loads only), marks the thread DONE, and returns to ISSUE_IDLE.
- `mem_valid` and all request fields stay stable until `mem_ready`. The only exception is `reset`.
- Ignored inputs and events:
  - REQUEST while a thread is not IDLE.
  - UPDATE while a thread is REQUESTING or WAITING; that thread keeps its state.
  - `mem_ready` while `mem_valid`=0.
  - A disabled thread never leaves IDLE.
- A store leaves `lsu_out[i]` unchanged.

## Timing
- Reset values:
  - `lsu_state` all IDLE.
  - `lsu_out` all 0.
  - `mem_valid`, `mem_write`, `mem_addr`, `mem_wdata` all 0.
  - Issuer in ISSUE_IDLE.
- An asserted `reset` forces `mem_valid` low without waiting for a clock edge, including in the middle of a transaction.
- With REQUEST sampled at edge N:
  - REQUESTING is visible after N.
  - The first thread is WAITING and `mem_valid` is high after N+1.
- With `mem_ready` tied high:
  - Each transaction takes 2 cycles (select, then handshake), with one `mem_valid`-low bubble between transactions.
  - All T threads reach DONE after edge N+2T.
- Each additional wait cycle on `mem_ready` adds one cycle to its transaction.
- Load data is visible on `lsu_out[i]` in the same cycle that `lsu_state[i]` reads DONE.

## Structure
- Shared package `core_pkg`:
  - `core_state` encodings (IDLE…DONE, 3 bits).
  - `lsu_state_t` enum (IDLE/REQUESTING/WAITING/DONE).
  - Issuer state enum.
- The scheduler also uses `core_pkg`.
- One sub-module, `lsu_thread_select`: a combinational lowest-index priority encoder over the REQUESTING mask. Outputs are `any` and `index`.

## Test plan
- Load, all 4 threads enabled, `rs`={3,2,1,0}, memory returns addr+8x10 with `mem_ready` high → addresses issued in order 0,1,2,3, one bubble between each; `lsu_out`={0x13,0x12,0x11,0x10}; all DONE after N+8.
- Store, `thread_enable`=4'b0101, `rt`={_,0xAA,_,0x55} → exactly two writes (thread0 0x55, thread2 0xAA); threads 1 and 3 stay IDLE; `lsu_out` unchanged.
- Backpressure: `mem_ready` low for 3 cycles on thread 0 → `mem_valid`, `mem_addr`, `mem_wdata` stay stable; thread 1 stays REQUESTING; thread 0 reaches DONE 4 cycles after issue.
- UPDATE with all threads DONE → all IDLE next cycle; a second REQUEST while threads are DONE has no effect.
- `reset` asserted mid-transaction (thread 1 WAITING) → `mem_valid`=0 before the next edge; all state IDLE; `lsu_out`=0.
- Read and write enable both high, `rs[0]`=0x40 → `mem_write`=0 on the issued request.
